armleocpu_ptw: RTL and testbench

- Sv32 hardware page-table walker, directly downstream of armleocpu_tlb.
- Consumes a TLB miss (20-bit VPN) and walks the two-level page table over a memory read port.
- Produces the 8-bit access tag and 22-bit PPN that drive the TLB write port (virtual_address_w / accesstag_w / phys_w), or reports a page or access fault.

---
 rtl/armleocpu_defines.sv | 28 ++
 rtl/armleocpu_ptw_if.sv | 39 +++
 rtl/armleocpu_ptw_pte_check.sv | 37 +++
 rtl/armleocpu_ptw.sv | 125 ++++++++++++
 tb/tb_armleocpu_ptw.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/armleocpu_defines.sv
// Shared Sv32 page-table-walker definitions: PTE bit positions, bus response
// codes and the walker state encoding.
package armleocpu_defines;

    localparam int PTE_V = 0;
    localparam int PTE_R = 1;
    localparam int PTE_W = 2;
    localparam int PTE_X = 3;
    localparam int PTE_U = 4;
    localparam int PTE_G = 5;
    localparam int PTE_A = 6;
    localparam int PTE_D = 7;

    localparam int PTE_PPN_HI = 31;
    localparam int PTE_PPN_LO = 10;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        PTW_IDLE,
        PTW_READ,
        PTW_WAIT_RESP,
        PTW_DONE
    } ptw_state_t;

endpackage

// File: rtl/armleocpu_ptw_if.sv
// Resolve request/response and memory read port of the Sv32 walker.
// master = walker side, slave = TLB/memory side.
interface armleocpu_ptw_if;

    logic        resolve_request;
    logic [19:0] resolve_virtual_address;
    logic [21:0] satp_ppn;
    logic        resolve_ack;
    logic        resolve_done;
    logic        resolve_pagefault;
    logic        resolve_accessfault;
    logic [19:0] resolve_virtual_address_w;
    logic [7:0]  resolve_accesstag;
    logic [21:0] resolve_physical_address;

    logic [33:0] avl_address;
    logic        avl_read;
    logic        avl_waitrequest;
    logic        avl_readdatavalid;
    logic [31:0] avl_readdata;
    logic [1:0]  avl_response;

    modport master (
        input  resolve_request, resolve_virtual_address, satp_ppn,
        output resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault,
        output resolve_virtual_address_w, resolve_accesstag, resolve_physical_address,
        output avl_address, avl_read,
        input  avl_waitrequest, avl_readdatavalid, avl_readdata, avl_response
    );

    modport slave (
        output resolve_request, resolve_virtual_address, satp_ppn,
        input  resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault,
        input  resolve_virtual_address_w, resolve_accesstag, resolve_physical_address,
        input  avl_address, avl_read,
        output avl_waitrequest, avl_readdatavalid, avl_readdata, avl_response
    );

endinterface

// File: rtl/armleocpu_ptw_pte_check.sv
// Combinational Sv32 PTE classification for one walk step.
// ARMLEOCPU_PTW_AD_CHECK_EN: fault on leaves with A=0, or W=1 and D=0.
module armleocpu_ptw_pte_check
    import armleocpu_defines::*;
(
    input  logic [31:0] pte,
    input  logic        level,
    input  logic [19:0] vpn,
    output logic        leaf,
    output logic        invalid,
    output logic        misaligned,
    output logic        pagefault,
    output logic [33:0] next_address,
    output logic [21:0] leaf_ppn
);

    logic ad_fault;
    logic fields_unused;

    always_comb begin
        invalid    = !pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]);
        leaf       = pte[PTE_R] || pte[PTE_X];
        misaligned = level && (pte[19:10] != '0);
`ifdef ARMLEOCPU_PTW_AD_CHECK_EN
        ad_fault   = !pte[PTE_A] || (pte[PTE_W] && !pte[PTE_D]);
`else
        ad_fault   = 1'b0;
`endif
        // A non-leaf at level 0 has nowhere left to point
        pagefault  = invalid || (leaf && (misaligned || ad_fault)) || (!leaf && !level);
        next_address = {pte[PTE_PPN_HI:PTE_PPN_LO], vpn[9:0], 2'b00};
        leaf_ppn     = level ? {pte[31:20], vpn[9:0]} : pte[PTE_PPN_HI:PTE_PPN_LO];
    end

    assign fields_unused = ^{pte[9:4], vpn[19:10]};

endmodule

// File: rtl/armleocpu_ptw.sv
// Sv32 two-level hardware page-table walker feeding the TLB write port.
// ARMLEOCPU_PTW_AD_CHECK_EN enables software-managed A/D fault checking.
module armleocpu_ptw
    import armleocpu_defines::*;
(
    input  logic            clk,
    input  logic            rst,
    armleocpu_ptw_if.master bus
);

    ptw_state_t  state, state_n;
    logic        level, level_n;
    logic [19:0] vpn_r, vpn_n;
    logic [33:0] addr_r, addr_n;
    logic [7:0]  tag_r, tag_n;
    logic [21:0] phys_r, phys_n;
    logic        pf_r, pf_n;
    logic        af_r, af_n;
    logic        ack;

    logic        pte_leaf;
    logic        pte_invalid;
    logic        pte_misaligned;
    logic        pte_pagefault;
    logic [33:0] pte_next_address;
    logic [21:0] pte_leaf_ppn;

    armleocpu_ptw_pte_check u_pte_check (
        .pte          (bus.avl_readdata),
        .level        (level),
        .vpn          (vpn_r),
        .leaf         (pte_leaf),
        .invalid      (pte_invalid),
        .misaligned   (pte_misaligned),
        .pagefault    (pte_pagefault),
        .next_address (pte_next_address),
        .leaf_ppn     (pte_leaf_ppn)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= PTW_IDLE;
            level  <= 1'b0;
            vpn_r  <= '0;
            addr_r <= '0;
            tag_r  <= '0;
            phys_r <= '0;
            pf_r   <= 1'b0;
            af_r   <= 1'b0;
        end else begin
            state  <= state_n;
            level  <= level_n;
            vpn_r  <= vpn_n;
            addr_r <= addr_n;
            tag_r  <= tag_n;
            phys_r <= phys_n;
            pf_r   <= pf_n;
            af_r   <= af_n;
        end
    end

    always_comb begin
        state_n = state;
        level_n = level;
        vpn_n   = vpn_r;
        addr_n  = addr_r;
        tag_n   = tag_r;
        phys_n  = phys_r;
        pf_n    = pf_r;
        af_n    = af_r;
        ack     = 1'b0;
        case (state)
            PTW_IDLE: begin
                if (bus.resolve_request && !rst) begin
                    ack     = 1'b1;
                    vpn_n   = bus.resolve_virtual_address;
                    level_n = 1'b1;
                    addr_n  = {bus.satp_ppn, bus.resolve_virtual_address[19:10], 2'b00};
                    state_n = PTW_READ;
                end
            end
            PTW_READ: begin
                if (!bus.avl_waitrequest)
                    state_n = PTW_WAIT_RESP;
            end
            PTW_WAIT_RESP: begin
                if (bus.avl_readdatavalid) begin
                    tag_n  = '0;
                    phys_n = '0;
                    pf_n   = 1'b0;
                    af_n   = 1'b0;
                    // Bus error outranks any PTE content
                    if (bus.avl_response != OKAY) begin
                        af_n    = 1'b1;
                        state_n = PTW_DONE;
                    end else if (pte_pagefault) begin
                        pf_n    = 1'b1;
                        state_n = PTW_DONE;
                    end else if (pte_leaf) begin
                        tag_n   = bus.avl_readdata[7:0];
                        phys_n  = pte_leaf_ppn;
                        state_n = PTW_DONE;
                    end else begin
                        level_n = 1'b0;
                        addr_n  = pte_next_address;
                        state_n = PTW_READ;
                    end
                end
            end
            PTW_DONE: state_n = PTW_IDLE;
            default:  state_n = PTW_IDLE;
        endcase
    end

    assign bus.resolve_ack               = ack;
    assign bus.resolve_done              = (state == PTW_DONE);
    assign bus.resolve_pagefault         = (state == PTW_DONE) && pf_r;
    assign bus.resolve_accessfault       = (state == PTW_DONE) && af_r;
    assign bus.resolve_virtual_address_w = vpn_r;
    assign bus.resolve_accesstag         = tag_r;
    assign bus.resolve_physical_address  = phys_r;
    assign bus.avl_address               = addr_r;
    assign bus.avl_read                  = (state == PTW_READ);

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Directed bench for armleocpu_ptw: page-table memory model, walk reference
// model and per-cycle output comparison.
`timescale 1ns/1ps
module tb_armleocpu_ptw;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    armleocpu_ptw_if bus();
    armleocpu_ptw dut (.clk(clk), .rst(rst), .bus(bus.master));

    logic [31:0] mem [logic [33:0]];
    bit          err_en = 0;
    logic [33:0] err_addr = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // walk expectation, owned by the driving task
    bit          exp_active = 0;
    int          exp_done_cyc;
    bit          exp_pf, exp_af;
    logic [7:0]  exp_tag;
    logic [21:0] exp_ppn;
    logic [19:0] exp_vpn;

    // last observed completion
    int          last_cyc;
    bit          last_pf, last_af;
    logic [7:0]  last_tag;
    logic [21:0] last_ppn;

    // memory responder controls
    int          wait_left = 0;
    int          resp_delay = 0;
    int          pend_cnt = 0;
    logic [33:0] pend_addr;
    int          reads_seen = 0;
    bit          stalled_last = 0;
    logic [33:0] stall_addr;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference walk straight from the Sv32 rules
    function automatic void model(input logic [21:0] satp, input logic [19:0] vpn,
                                  output bit pf, output bit af, output logic [7:0] tag,
                                  output logic [21:0] ppn, output int n);
        logic [33:0] a;
        logic [31:0] pte;
        bit lvl1;
        pf = 0; af = 0; tag = '0; ppn = '0; n = 0;
        a = {satp, vpn[19:10], 2'b00};
        lvl1 = 1;
        for (int k = 0; k < 2; k++) begin
            n++;
            if (err_en && a == err_addr) begin af = 1; return; end
            pte = mem.exists(a) ? mem[a] : 32'h0;
            if (!pte[0] || (!pte[1] && pte[2])) begin pf = 1; return; end
            if (pte[1] || pte[3]) begin
                if (lvl1 && pte[19:10] != 10'h0) begin pf = 1; return; end
`ifdef ARMLEOCPU_PTW_AD_CHECK_EN
                if (!pte[6] || (pte[2] && !pte[7])) begin pf = 1; return; end
`endif
                tag = pte[7:0];
                ppn = lvl1 ? {pte[31:20], vpn[9:0]} : pte[31:10];
                return;
            end
            if (!lvl1) begin pf = 1; return; end
            a = {pte[31:10], vpn[9:0], 2'b00};
            lvl1 = 0;
        end
    endfunction

    // Memory responder: decides waitrequest for the current cycle and returns
    // data a cycle (plus resp_delay) after the read is accepted.
    always @(negedge clk) begin
        #1;
        bus.avl_readdatavalid = 1'b0;
        bus.avl_readdata      = 32'hFFFF_FFFF;
        bus.avl_response      = 2'b11;
        if (stalled_last) begin
            chk("stall_read_held", bus.avl_read, 1);
            chk("stall_addr_stable", bus.avl_address, stall_addr);
            stalled_last = 0;
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                bus.avl_readdatavalid = 1'b1;
                bus.avl_readdata      = mem.exists(pend_addr) ? mem[pend_addr] : 32'h0;
                bus.avl_response      = (err_en && pend_addr == err_addr) ? 2'b10 : 2'b00;
            end
        end
        if (bus.avl_read && !rst) begin
            if (wait_left > 0) begin
                bus.avl_waitrequest = 1'b1;
                // unsolicited strobe of an invalid PTE while still in READ
                bus.avl_readdatavalid = 1'b1;
                bus.avl_readdata      = 32'h0;
                bus.avl_response      = 2'b00;
                wait_left--;
                stalled_last = 1;
                stall_addr   = bus.avl_address;
            end else begin
                bus.avl_waitrequest = 1'b0;
                pend_cnt  = 1 + resp_delay;
                pend_addr = bus.avl_address;
                reads_seen++;
            end
        end else begin
            bus.avl_waitrequest = 1'b0;
        end
    end

    // Compare process: every completion against the model, flags every cycle
    always @(negedge clk) begin
        if (!rst)
            chk("flags_only_with_done",
                (bus.resolve_pagefault || bus.resolve_accessfault) && !bus.resolve_done, 0);
        if (bus.resolve_done) begin
            last_cyc = cyc;
            last_pf  = bus.resolve_pagefault;
            last_af  = bus.resolve_accessfault;
            last_tag = bus.resolve_accesstag;
            last_ppn = bus.resolve_physical_address;
            checks++;
            if (!exp_active) begin
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                chk("done_cycle", cyc, exp_done_cyc);
                chk("pagefault", last_pf, exp_pf);
                chk("accessfault", last_af, exp_af);
                chk("accesstag", last_tag, exp_tag);
                chk("phys", last_ppn, exp_ppn);
                chk("vpn_w", bus.resolve_virtual_address_w, exp_vpn);
                chk("flags_exclusive", last_pf && last_af, 0);
                exp_active = 0;
            end
        end
    end

    task automatic run_walk(input string name, input logic [21:0] satp, input logic [19:0] vpn,
                            input int stalls, input bit hold_req,
                            output int lat, output int nreads);
        bit pf, af;
        logic [7:0] tag;
        logic [21:0] ppn;
        int n, t0, r0;
        model(satp, vpn, pf, af, tag, ppn, n);
        exp_pf = pf; exp_af = af; exp_tag = tag; exp_ppn = ppn; exp_vpn = vpn;
        wait_left = stalls;
        r0 = reads_seen;
        @(posedge clk); #1;
        bus.resolve_request = 1'b1;
        bus.resolve_virtual_address = vpn;
        bus.satp_ppn = satp;
        @(negedge clk);
        chk({name, "_ack"}, bus.resolve_ack, 1);
        t0 = cyc;
        exp_done_cyc = cyc + 2 * n + 1 + stalls;
        exp_active = 1;
        @(posedge clk); #1;
        if (!hold_req) begin
            bus.resolve_request = 1'b0;
            bus.resolve_virtual_address = ~vpn;
            bus.satp_ppn = ~satp;
        end
        for (int i = 0; i < 60 && exp_active; i++) begin
            @(negedge clk);
            if (bus.resolve_done) bus.resolve_request = 1'b0;
            else if (hold_req) chk({name, "_ack_while_busy"}, bus.resolve_ack, 0);
            #2;
        end
        if (exp_active) begin
            failures++;
            checks++;
            $display("FAIL %s_timeout actual=no_done required=done_by_cycle_%0d", name, exp_done_cyc);
            exp_active = 0;
            last_cyc = t0;
        end
        bus.resolve_request = 1'b0;
        lat = last_cyc - t0;
        nreads = reads_seen - r0;
    endtask

    int lat, nr;

    initial begin
        rst = 1'b1;
        bus.resolve_request = 1'b0;
        bus.resolve_virtual_address = '0;
        bus.satp_ppn = '0;
        bus.avl_waitrequest = 1'b0;
        bus.avl_readdatavalid = 1'b0;
        bus.avl_readdata = '0;
        bus.avl_response = 2'b00;

        mem[34'h1400] = 32'h2000_00CF;  // megapage
        mem[34'h3400] = 32'h0000_0801;  // pointer to PPN 0x2
        mem[34'h248C] = 32'h0ABC_D0DF;  // 4K leaf
        mem[34'h4400] = 32'h0000_00CE;  // V=0
        mem[34'h5400] = 32'h0000_0407;  // misaligned megapage
        mem[34'h6400] = 32'h0000_0C01;  // pointer to PPN 0x3
        mem[34'h348C] = 32'h0000_0001;  // pointer at level 0
        mem[34'h7400] = 32'h0000_0801;  // behind a bus error
        mem[34'h8400] = 32'h0000_0047;  // A=1 W=1 D=0
        mem[34'h9400] = 32'h0000_0005;  // W without R

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", bus.resolve_ack, 0);
        chk("rst_done", bus.resolve_done, 0);
        chk("rst_pf", bus.resolve_pagefault, 0);
        chk("rst_af", bus.resolve_accessfault, 0);
        chk("rst_vpn_w", bus.resolve_virtual_address_w, 0);
        chk("rst_tag", bus.resolve_accesstag, 0);
        chk("rst_phys", bus.resolve_physical_address, 0);
        chk("rst_avl_address", bus.avl_address, 0);
        chk("rst_avl_read", bus.avl_read, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_walk("mega", 22'h00001, 20'h40123, 0, 0, lat, nr);
        chk("mega_latency", lat, 3);
        chk("mega_tag_lit", last_tag, 8'hCF);
        chk("mega_phys_lit", last_ppn, 22'h080123);
        chk("mega_fault_lit", {last_pf, last_af}, 2'b00);

        run_walk("page4k", 22'h00003, 20'h40123, 0, 1, lat, nr);
        chk("page4k_latency", lat, 5);
        chk("page4k_reads", nr, 2);
        chk("page4k_tag_lit", last_tag, 8'hDF);
        chk("page4k_phys_lit", last_ppn, 22'h02AF34);

        run_walk("invalid", 22'h00004, 20'h40123, 0, 0, lat, nr);
        chk("invalid_pf_lit", last_pf, 1);
        run_walk("misaligned", 22'h00005, 20'h40123, 0, 0, lat, nr);
        chk("misaligned_pf_lit", last_pf, 1);
        run_walk("w_no_r", 22'h00009, 20'h40123, 0, 0, lat, nr);
        chk("w_no_r_pf_lit", last_pf, 1);

        run_walk("ptr_l0", 22'h00006, 20'h40123, 0, 0, lat, nr);
        chk("ptr_l0_pf_lit", last_pf, 1);
        chk("ptr_l0_data_lit", {last_tag, last_ppn}, 30'h0);

        err_en = 1; err_addr = 34'h7400;
        run_walk("buserr", 22'h00007, 20'h40123, 0, 0, lat, nr);
        chk("buserr_flags_lit", {last_af, last_pf}, 2'b10);
        chk("buserr_reads_lit", nr, 1);
        err_en = 0;

        run_walk("stall", 22'h00001, 20'h40123, 5, 0, lat, nr);
        chk("stall_latency", lat, 8);
        chk("stall_phys_lit", last_ppn, 22'h080123);

        // Reset while waiting for the first PTE; its data lands in IDLE
        resp_delay = 2;
        @(posedge clk); #1;
        bus.resolve_request = 1'b1;
        bus.resolve_virtual_address = 20'h40123;
        bus.satp_ppn = 22'h00003;
        @(negedge clk);
        chk("rstmid_ack", bus.resolve_ack, 1);
        @(posedge clk); #1;
        bus.resolve_request = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rstmid_no_read", bus.avl_read, 0);
            chk("rstmid_no_done", bus.resolve_done, 0);
        end
        resp_delay = 0;
        run_walk("after_rst", 22'h00003, 20'h40123, 0, 0, lat, nr);
        chk("after_rst_latency", lat, 5);
        chk("after_rst_phys_lit", last_ppn, 22'h02AF34);

        run_walk("ad", 22'h00008, 20'h40123, 0, 0, lat, nr);
`ifdef ARMLEOCPU_PTW_AD_CHECK_EN
        chk("ad_pf_lit", last_pf, 1);
`else
        chk("ad_tag_lit", last_tag, 8'h47);
        chk("ad_phys_lit", last_ppn, 22'h000123);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
